// File: rtl/lockstep_pkg.sv
// lockstep_pkg
//   Shared types and constants for the lockstep memory sequencer.
//   - lane_state_t : per-lane sequencer state (IDLE, LOAD, EXEC, STOP), 2 bits
//   - FAULT_CNT_W  : width of the saturating mismatch counter
//   - FAULT_CNT_MAX: value at which the mismatch counter stops counting
package lockstep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    STOP = 2'd3
  } lane_state_t;

  localparam int FAULT_CNT_W = 8;
  localparam logic [FAULT_CNT_W-1:0] FAULT_CNT_MAX = '1;

endpackage

// File: rtl/memseq_lane.sv
// memseq_lane
//   One redundant lane: a four-state sequencer, an AW-bit address counter
//   and a 2**AW x DW memory. LOAD fills the memory with cnt ^ SEED (with an
//   optional bit-0 inversion for fault injection), EXEC reads it back in
//   descending address order.
// Ports:
//   clk     in   clock, rising edge
//   rstn    in   synchronous active-low reset (memory contents untouched)
//   start   in   begin a run, only looked at in IDLE
//   inj     in   invert bit 0 of the word written this cycle (LOAD only)
//   state   out  current sequencer state
//   cnt     out  current address counter
//   rd_data out  combinational read of mem[cnt]
module memseq_lane
  import lockstep_pkg::*;
#(
  parameter int              DW   = 8,
  parameter int              AW   = 8,
  parameter logic [DW-1:0]   SEED = DW'(8'hA5)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              inj,
  output lane_state_t       state,
  output logic [AW-1:0]     cnt,
  output logic [DW-1:0]     rd_data
);

  localparam int            DEPTH   = 2 ** AW;
  localparam logic [AW-1:0] CNT_MAX = '1;

  lane_state_t   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [DEPTH];

  // Next-state and counter logic. The counter climbs through LOAD, holds at
  // all-ones on the LOAD->EXEC transition so EXEC starts at the top address,
  // then walks down to zero before STOP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        wr_en = 1'b1;
        if (cnt_q == CNT_MAX) state_d = EXEC;
        else                  cnt_d   = cnt_q + AW'(1);
      end
      EXEC: begin
        if (cnt_q == '0) state_d = STOP;
        else             cnt_d   = cnt_q - AW'(1);
      end
      STOP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write pattern: counter zero-extended or truncated to DW, XORed with the
  // seed. Injection flips only bit 0 so a faulty word differs by exactly one
  // bit from its healthy twin.
  always_comb begin
    wr_data = DW'(cnt_q) ^ SEED ^ DW'(inj);
  end

  // Memory write port. Deliberately not reset so contents survive rstn.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) mem[cnt_q] <= wr_data;
  end

  // Asynchronous read of the current address; the top decides when it is used.
  always_comb begin
    rd_data = mem[cnt_q];
  end

  assign state = state_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/lockstep_memseq.sv
// lockstep_memseq
//   NCH identical memseq_lane instances run in lockstep from the same inputs.
//   The top votes the read data (lane 0 for NCH=2, bitwise majority for
//   NCH=3), compares lanes during EXEC and keeps sticky fault information.
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   synchronous active-low reset
//   start      in   begin a run (IDLE only)
//   inj_en     in   fault injection strobe (effective in LOAD only)
//   inj_lane   in   lane select mask for injection
//   clr_fault  in   clear sticky fault state (a same-cycle mismatch wins)
//   busy       out  high in LOAD, EXEC, STOP
//   rd_valid   out  high in EXEC
//   rd_data    out  voted read data, 0 when rd_valid is low
//   done       out  one-cycle pulse in STOP
//   fault      out  sticky mismatch flag
//   fault_lane out  sticky per-lane blame mask
//   fault_cnt  out  saturating count of mismatching EXEC cycles
module lockstep_memseq
  import lockstep_pkg::*;
#(
  parameter int            DW   = 8,
  parameter int            AW   = 8,
  parameter int            NCH  = 2,
  parameter logic [DW-1:0] SEED = DW'(8'hA5)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   inj_en,
  input  logic [NCH-1:0]         inj_lane,
  input  logic                   clr_fault,
  output logic                   busy,
  output logic                   rd_valid,
  output logic [DW-1:0]          rd_data,
  output logic                   done,
  output logic                   fault,
  output logic [NCH-1:0]         fault_lane,
  output logic [FAULT_CNT_W-1:0] fault_cnt
);

  if (NCH != 2 && NCH != 3) begin : g_bad_nch
    $error("lockstep_memseq: NCH must be 2 or 3");
  end

  lane_state_t   lane_state [NCH];
  logic [AW-1:0] lane_cnt   [NCH];
  logic [DW-1:0] lane_data  [NCH];
  logic [AW+1:0] lane_tag   [NCH];
  logic [DW-1:0] voted;
  logic [NCH-1:0] blame;
  logic          any_exec;
  logic          mismatch;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    memseq_lane #(
      .DW  (DW),
      .AW  (AW),
      .SEED(SEED)
    ) u_lane (
      .clk    (clk),
      .rstn   (rstn),
      .start  (start),
      .inj    (inj_en & inj_lane[g]),
      .state  (lane_state[g]),
      .cnt    (lane_cnt[g]),
      .rd_data(lane_data[g])
    );
  end

  // Each lane's control state is folded into one tag so that a diverged FSM
  // or counter is caught even when the read data happens to agree. Any lane
  // in EXEC opens the compare window, so a lane stuck outside EXEC while the
  // others read is still seen.
  always_comb begin
    any_exec = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      lane_tag[i] = {lane_state[i], lane_cnt[i]};
      any_exec    = any_exec | (lane_state[i] == EXEC);
    end
  end

  if (NCH == 3) begin : g_tmr
    // Bitwise 2-of-3 vote. A lane is blamed when its data disagrees with the
    // vote, or when its control tag disagrees with both other lanes (if all
    // three tags differ every lane gets blamed).
    always_comb begin
      voted = (lane_data[0] & lane_data[1]) |
              (lane_data[0] & lane_data[2]) |
              (lane_data[1] & lane_data[2]);
      blame[0] = (lane_data[0] != voted) |
                 ((lane_tag[0] != lane_tag[1]) & (lane_tag[0] != lane_tag[2]));
      blame[1] = (lane_data[1] != voted) |
                 ((lane_tag[1] != lane_tag[0]) & (lane_tag[1] != lane_tag[2]));
      blame[2] = (lane_data[2] != voted) |
                 ((lane_tag[2] != lane_tag[0]) & (lane_tag[2] != lane_tag[1]));
    end
  end else begin : g_dmr
    // With two lanes there is no way to tell which one is wrong, so any
    // disagreement blames both and lane 0 supplies the data.
    always_comb begin
      voted = lane_data[0];
      blame = ((lane_data[0] != lane_data[1]) || (lane_tag[0] != lane_tag[1])) ? '1 : '0;
    end
  end

  assign mismatch = any_exec & (|blame);

  // Sticky fault state, updated one cycle after the offending EXEC cycle.
  // A mismatch takes priority over clr_fault and restarts the history with
  // the new blame and a count of one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fault      <= 1'b0;
      fault_lane <= '0;
      fault_cnt  <= '0;
    end else if (mismatch) begin
      fault      <= 1'b1;
      fault_lane <= clr_fault ? blame : (fault_lane | blame);
      if (clr_fault)                       fault_cnt <= FAULT_CNT_W'(1);
      else if (fault_cnt != FAULT_CNT_MAX) fault_cnt <= fault_cnt + FAULT_CNT_W'(1);
    end else if (clr_fault) begin
      fault      <= 1'b0;
      fault_lane <= '0;
      fault_cnt  <= '0;
    end
  end

  // Handshake outputs come from lane 0 only; divergence is reported through
  // the fault path rather than by disturbing these.
  always_comb begin
    busy     = (lane_state[0] != IDLE);
    rd_valid = (lane_state[0] == EXEC);
    done     = (lane_state[0] == STOP);
    rd_data  = rd_valid ? voted : '0;
  end

endmodule

// File: tb/tb_lockstep_memseq.sv
// tb_lockstep_memseq
//   Drives a 2-lane and a 3-lane lockstep_memseq (AW=4, DW=8, SEED=A5) from
//   shared stimulus. Expected read words and blame masks are queued while
//   LOAD is driven and popped as EXEC reads them back (highest address first).
module tb_lockstep_memseq;

  localparam int         DW   = 8;
  localparam int         AW   = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk       = 1'b0;
  logic       rstn      = 1'b0;
  logic       start     = 1'b0;
  logic       inj_en    = 1'b0;
  logic       clr_fault = 1'b0;
  logic [1:0] inj_lane2 = '0;
  logic [2:0] inj_lane3 = '0;

  logic       busy2, rd_valid2, done2, fault2;
  logic [7:0] rd_data2, fault_cnt2;
  logic [1:0] fault_lane2;
  logic       busy3, rd_valid3, done3, fault3;
  logic [7:0] rd_data3, fault_cnt3;
  logic [2:0] fault_lane3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q2 [$];
  logic [7:0] q3 [$];
  logic [1:0] bq2 [$];
  logic [2:0] bq3 [$];

  logic       ef2, ef3;
  logic [1:0] el2;
  logic [2:0] el3;
  logic [7:0] ec2, ec3;

  lockstep_memseq #(.DW(DW), .AW(AW), .NCH(2), .SEED(SEED)) dut2 (
    .clk(clk), .rstn(rstn), .start(start), .inj_en(inj_en), .inj_lane(inj_lane2),
    .clr_fault(clr_fault), .busy(busy2), .rd_valid(rd_valid2), .rd_data(rd_data2),
    .done(done2), .fault(fault2), .fault_lane(fault_lane2), .fault_cnt(fault_cnt2)
  );

  lockstep_memseq #(.DW(DW), .AW(AW), .NCH(3), .SEED(SEED)) dut3 (
    .clk(clk), .rstn(rstn), .start(start), .inj_en(inj_en), .inj_lane(inj_lane3),
    .clr_fault(clr_fault), .busy(busy3), .rd_valid(rd_valid3), .rd_data(rd_data3),
    .done(done3), .fault(fault3), .fault_lane(fault_lane3), .fault_cnt(fault_cnt3)
  );

  always #5 clk = ~clk;

  // Safety net in case something blocks forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the sticky fault registers for one clock edge.
  task automatic model_step(input logic [1:0] b2, input logic [2:0] b3, input logic clr);
    if (b2 != 2'b00) begin
      ef2 = 1'b1;
      el2 = clr ? b2 : (el2 | b2);
      ec2 = clr ? 8'd1 : ((ec2 == 8'hFF) ? ec2 : ec2 + 8'd1);
    end else if (clr) begin
      ef2 = 1'b0; el2 = '0; ec2 = '0;
    end
    if (b3 != 3'b000) begin
      ef3 = 1'b1;
      el3 = clr ? b3 : (el3 | b3);
      ec3 = clr ? 8'd1 : ((ec3 == 8'hFF) ? ec3 : ec3 + 8'd1);
    end else if (clr) begin
      ef3 = 1'b0; el3 = '0; ec3 = '0;
    end
  endtask

  task automatic model_clear();
    ef2 = 1'b0; el2 = '0; ec2 = '0;
    ef3 = 1'b0; el3 = '0; ec3 = '0;
  endtask

  // One full run from IDLE. atN = LOAD address to inject at (16 = every
  // address, -1 = none), clr_at = EXEC address at which clr_fault is raised.
  // Returns one cycle after STOP, i.e. back in IDLE.
  task automatic run_pass(input int at2, input logic [1:0] m2, input int at3,
                          input logic [2:0] m3, input int clr_at,
                          input bit pulse_start, input bit hold_start);
    int         cyc;
    int         c;
    int         pc;
    bit         seen_done;
    logic [7:0] base, e2, e3;
    logic [1:0] b2;
    logic [2:0] b3;
    start = 1'b1;
    tick();
    cyc = 1;
    for (int a = 0; a < 16; a++) begin
      n_checks++;
      if (busy2 !== 1'b1 || busy3 !== 1'b1 || rd_valid2 !== 1'b0 || rd_valid3 !== 1'b0 ||
          rd_data2 !== 8'h00 || rd_data3 !== 8'h00 || done2 !== 1'b0 || done3 !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL load_flags a=%0d: got busy=%b/%b rv=%b/%b rd=%h/%h done=%b/%b required busy=1 rv=0 rd=00 done=0",
                 a, busy2, busy3, rd_valid2, rd_valid3, rd_data2, rd_data3, done2, done3);
      end
      start     = hold_start ? 1'b1 : (pulse_start && a == 5);
      inj_lane2 = (at2 == a || at2 == 16) ? m2 : 2'b00;
      inj_lane3 = (at3 == a || at3 == 16) ? m3 : 3'b000;
      inj_en    = (inj_lane2 != 2'b00) || (inj_lane3 != 3'b000);
      base = a[7:0] ^ SEED;
      e2   = base ^ {7'b0, inj_lane2[0]};
      b2   = (inj_lane2 == 2'b01 || inj_lane2 == 2'b10) ? 2'b11 : 2'b00;
      pc   = $countones(inj_lane3);
      e3   = base ^ {7'b0, (pc >= 2)};
      b3   = (pc == 1) ? inj_lane3 : ((pc == 2) ? ~inj_lane3 : 3'b000);
      q2.push_back(e2);
      bq2.push_back(b2);
      q3.push_back(e3);
      bq3.push_back(b3);
      tick();
      cyc++;
    end
    inj_en    = 1'b0;
    inj_lane2 = '0;
    inj_lane3 = '0;
    start     = hold_start;
    seen_done = 1'b0;
    for (int k = 0; k < 24 && !seen_done; k++) begin
      if (done2 === 1'b1 || done3 === 1'b1) begin
        seen_done = 1'b1;
        n_checks++;
        if (cyc != 33) begin
          n_fail++;
          $display("[TB] FAIL done_latency: got %0d cycles after start, required 33", cyc);
        end
        n_checks++;
        if (done2 !== 1'b1 || done3 !== 1'b1 || busy2 !== 1'b1 || rd_valid2 !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL stop_flags: got done=%b/%b busy=%b rv=%b required done=1/1 busy=1 rv=0",
                   done2, done3, busy2, rd_valid2);
        end
        n_checks++;
        if (q2.size() != 0 || q3.size() != 0) begin
          n_fail++;
          $display("[TB] FAIL exec_length: got %0d/%0d unread words, required 0", q2.size(), q3.size());
        end
      end else begin
        n_checks++;
        if (fault2 !== ef2 || fault_lane2 !== el2 || fault_cnt2 !== ec2) begin
          n_fail++;
          $display("[TB] FAIL fault2_exec cyc=%0d: got %b/%b/%0d required %b/%b/%0d",
                   cyc, fault2, fault_lane2, fault_cnt2, ef2, el2, ec2);
        end
        n_checks++;
        if (fault3 !== ef3 || fault_lane3 !== el3 || fault_cnt3 !== ec3) begin
          n_fail++;
          $display("[TB] FAIL fault3_exec cyc=%0d: got %b/%b/%0d required %b/%b/%0d",
                   cyc, fault3, fault_lane3, fault_cnt3, ef3, el3, ec3);
        end
        b2 = '0;
        b3 = '0;
        clr_fault = 1'b0;
        if (q2.size() == 0 || q3.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL exec_overrun cyc=%0d: got done=%b busy=%b, required done=1", cyc, done2, busy2);
        end else begin
          e2 = q2.pop_back();
          b2 = bq2.pop_back();
          e3 = q3.pop_back();
          b3 = bq3.pop_back();
          c  = q2.size();
          n_checks++;
          if (rd_valid2 !== 1'b1 || rd_data2 !== e2 || busy2 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rd2 cnt=%0d: got rv=%b data=%h busy=%b required rv=1 data=%h busy=1",
                     c, rd_valid2, rd_data2, busy2, e2);
          end
          n_checks++;
          if (rd_valid3 !== 1'b1 || rd_data3 !== e3) begin
            n_fail++;
            $display("[TB] FAIL rd3 cnt=%0d: got rv=%b data=%h required rv=1 data=%h",
                     c, rd_valid3, rd_data3, e3);
          end
          clr_fault = (c == clr_at);
        end
        model_step(b2, b3, clr_fault);
        tick();
        cyc++;
        clr_fault = 1'b0;
      end
    end
    if (!seen_done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL done_timeout: got no done by cycle %0d, required done at 33", cyc);
    end else begin
      n_checks++;
      if (fault2 !== ef2 || fault_lane2 !== el2 || fault_cnt2 !== ec2 ||
          fault3 !== ef3 || fault_lane3 !== el3 || fault_cnt3 !== ec3) begin
        n_fail++;
        $display("[TB] FAIL fault_at_done: got %b/%b/%0d %b/%b/%0d required %b/%b/%0d %b/%b/%0d",
                 fault2, fault_lane2, fault_cnt2, fault3, fault_lane3, fault_cnt3,
                 ef2, el2, ec2, ef3, el3, ec3);
      end
    end
    start = hold_start || pulse_start;
    tick();
    q2.delete();
    q3.delete();
    bq2.delete();
    bq3.delete();
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rstn = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy2 !== 1'b0 || rd_valid2 !== 1'b0 || done2 !== 1'b0 || rd_data2 !== 8'h00 ||
        busy3 !== 1'b0 || rd_valid3 !== 1'b0 || done3 !== 1'b0 || rd_data3 !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got busy=%b/%b rv=%b/%b done=%b/%b rd=%h/%h required all 0",
               busy2, busy3, rd_valid2, rd_valid3, done2, done3, rd_data2, rd_data3);
    end
    n_checks++;
    if (fault2 !== 1'b0 || fault_lane2 !== 2'b00 || fault_cnt2 !== 8'd0 ||
        fault3 !== 1'b0 || fault_lane3 !== 3'b000 || fault_cnt3 !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_fault: got %b/%b/%0d %b/%b/%0d required all 0",
               fault2, fault_lane2, fault_cnt2, fault3, fault_lane3, fault_cnt3);
    end
    rstn = 1'b1;
    tick();
    n_checks++;
    if (busy2 !== 1'b0 || busy3 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got busy=%b/%b required 0/0", busy2, busy3);
    end
    model_clear();
  endtask

  task automatic test_clean_run();
    $display("[TB] test_clean_run");
    run_pass(-1, 2'b00, -1, 3'b000, -1, 1'b0, 1'b0);
  endtask

  task automatic test_inject();
    $display("[TB] test_inject");
    run_pass(3, 2'b10, 5, 3'b100, -1, 1'b0, 1'b0);
    n_checks++;
    if (fault2 !== 1'b1 || fault_lane2 !== 2'b11 || fault_cnt2 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL inject_dmr: got %b/%b/%0d required 1/11/1", fault2, fault_lane2, fault_cnt2);
    end
    n_checks++;
    if (fault3 !== 1'b1 || fault_lane3 !== 3'b100 || fault_cnt3 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL inject_tmr: got %b/%b/%0d required 1/100/1", fault3, fault_lane3, fault_cnt3);
    end
  endtask

  task automatic test_sticky_clear();
    $display("[TB] test_sticky_clear");
    run_pass(7, 2'b01, 7, 3'b010, -1, 1'b0, 1'b0);
    run_pass(2, 2'b10, 2, 3'b001, 2, 1'b0, 1'b0);
    n_checks++;
    if (fault2 !== 1'b1 || fault_cnt2 !== 8'd1 || fault3 !== 1'b1 ||
        fault_lane3 !== 3'b001 || fault_cnt3 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL clear_vs_mismatch: got %b/%0d %b/%b/%0d required 1/1 1/001/1",
               fault2, fault_cnt2, fault3, fault_lane3, fault_cnt3);
    end
  endtask

  task automatic test_reset_mid();
    $display("[TB] test_reset_mid");
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16 + 7; i++) tick();
    n_checks++;
    if (rd_valid2 !== 1'b1 || rd_data2 !== (8'h08 ^ SEED)) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_read: got rv=%b data=%h required rv=1 data=%h",
               rd_valid2, rd_data2, 8'h08 ^ SEED);
    end
    rstn = 1'b0;
    tick();
    n_checks++;
    if (busy2 !== 1'b0 || rd_valid2 !== 1'b0 || rd_data2 !== 8'h00 || done2 !== 1'b0 ||
        busy3 !== 1'b0 || rd_valid3 !== 1'b0 || rd_data3 !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_flags: got busy=%b/%b rv=%b/%b rd=%h/%h required all 0",
               busy2, busy3, rd_valid2, rd_valid3, rd_data2, rd_data3);
    end
    n_checks++;
    if (fault2 !== 1'b0 || fault_cnt2 !== 8'd0 || fault3 !== 1'b0 || fault_lane3 !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_fault: got %b/%0d %b/%b required 0/0 0/000",
               fault2, fault_cnt2, fault3, fault_lane3);
    end
    rstn = 1'b1;
    model_clear();
    tick();
    run_pass(-1, 2'b00, -1, 3'b000, -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    $display("[TB] test_start_ignored");
    run_pass(-1, 2'b00, -1, 3'b000, -1, 1'b1, 1'b0);
    start = 1'b0;
    n_checks++;
    if (busy2 !== 1'b0 || busy3 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_in_stop: got busy=%b/%b required 0/0", busy2, busy3);
    end
    tick();
    n_checks++;
    if (busy2 !== 1'b0 || busy3 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stays_idle: got busy=%b/%b required 0/0", busy2, busy3);
    end
  endtask

  task automatic test_start_held();
    $display("[TB] test_start_held");
    run_pass(-1, 2'b00, -1, 3'b000, -1, 1'b0, 1'b1);
    n_checks++;
    if (busy2 !== 1'b0 || busy3 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL held_idle_gap: got busy=%b/%b required 0/0", busy2, busy3);
    end
    tick();
    n_checks++;
    if (busy2 !== 1'b1 || busy3 !== 1'b1 || rd_valid2 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL held_restart: got busy=%b/%b rv=%b required busy=1/1 rv=0",
               busy2, busy3, rd_valid2);
    end
    start = 1'b0;
    rstn  = 1'b0;
    tick();
    rstn = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic test_saturate();
    $display("[TB] test_saturate");
    for (int r = 0; r < 17; r++) run_pass(16, 2'b01, 16, 3'b001, -1, 1'b0, 1'b0);
    n_checks++;
    if (fault_cnt2 !== 8'd255 || fault_cnt3 !== 8'd255 || fault_lane3 !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL saturate: got %0d/%0d lane3=%b required 255/255 lane3=001",
               fault_cnt2, fault_cnt3, fault_lane3);
    end
  endtask

  task automatic test_clear_idle();
    $display("[TB] test_clear_idle");
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    model_step(2'b00, 3'b000, 1'b1);
    n_checks++;
    if (fault2 !== ef2 || fault_lane2 !== el2 || fault_cnt2 !== ec2 ||
        fault3 !== ef3 || fault_lane3 !== el3 || fault_cnt3 !== ec3) begin
      n_fail++;
      $display("[TB] FAIL clear_idle: got %b/%b/%0d %b/%b/%0d required all 0",
               fault2, fault_lane2, fault_cnt2, fault3, fault_lane3, fault_cnt3);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_run();
    test_inject();
    test_sticky_clear();
    test_reset_mid();
    test_start_ignored();
    test_start_held();
    test_saturate();
    test_clear_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lockstep_memseq.md
LOCKSTEP_MEMSEQ -- requirements
Module: lockstep_memseq

Interface
REQ-001 SHALL have parameter DW, default 8: memory data width, 1..32.
REQ-002 SHALL have parameter AW, default 8: address/counter width, 1..10; depth 2**AW.
REQ-003 SHALL have parameter NCH, default 2: redundant lane count; only 2 or 3 legal, any other value is an elaboration error.
REQ-004 SHALL have parameter SEED, default 'hA5: DW-bit XOR pattern applied to write data.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  begin a run; sampled only in IDLE.
REQ-008 inj_en  in  1  fault injection strobe; honoured only in LOAD.
REQ-009 inj_lane  in  NCH  one-hot/multi-hot lane select for injection.
REQ-010 clr_fault  in  1  clears sticky fault state.
REQ-011 busy  out  1  high in LOAD, EXEC, STOP.
REQ-012 rd_valid  out  1  high in EXEC only.
REQ-013 rd_data  out  DW  voted read data; 0 when rd_valid low.
REQ-014 done  out  1  one-cycle pulse in STOP.
REQ-015 fault  out  1  sticky mismatch flag.
REQ-016 fault_lane  out  NCH  sticky per-lane blame mask.
REQ-017 fault_cnt  out  8  saturating count of mismatching EXEC cycles.

Function
REQ-018 Each lane SHALL hold an identical FSM IDLE->LOAD->EXEC->STOP->IDLE, an AW-bit counter and a 2**AW x DW memory, all driven by the same inputs.
REQ-019 IDLE: counter 0; start=1 -> LOAD next cycle; start ignored in every other state.
REQ-020 LOAD: write mem[cnt] = zext/trunc(cnt, DW) ^ SEED; if cnt == all-ones -> EXEC with cnt held, else cnt+1.
REQ-021 inj_en in LOAD SHALL invert bit 0 of write data for lanes selected by inj_lane, that cycle only.
REQ-022 EXEC: each lane reads mem[cnt] combinationally; if cnt == 0 -> STOP, else cnt-1.
REQ-023 STOP: done=1 for exactly one cycle -> IDLE; start in STOP has no effect.
REQ-024 Run length from start sample: 2**AW LOAD + 2**AW EXEC + 1 STOP cycles; done asserted 2**(AW+1)+1 cycles after start is sampled.
REQ-025 Lane FSMs, counters and busy/rd_valid/done SHALL be taken from lane 0; any lane-state divergence also counts as mismatch.
REQ-026 rd_data: NCH=2 -> lane 0 data; NCH=3 -> bitwise 2-of-3 majority.
REQ-027 Mismatch: in EXEC, any lane read data differs from another; no mismatch evaluated outside EXEC.
REQ-028 Blame: NCH=2 -> both bits on mismatch; NCH=3 -> bit i where lane i differs from majority (all bits if no majority on any bit position is impossible; majority always exists bitwise).
REQ-029 fault, fault_lane (OR-accumulate) and fault_cnt SHALL update the cycle after the mismatching EXEC cycle (registered, 1-cycle latency).
REQ-030 fault_cnt SHALL saturate at 255, never wrap.
REQ-031 clr_fault clears fault, fault_lane, fault_cnt next cycle; a mismatch in the same cycle wins: fault=1, fault_lane=new blame, fault_cnt=1.

Reset
REQ-032 rstn=0 at any clock edge, including mid-LOAD/EXEC: all lanes IDLE, counters 0, busy/rd_valid/done/rd_data 0, fault/fault_lane/fault_cnt 0.
REQ-033 Memory contents SHALL NOT be reset.

Structure
REQ-034 Package lockstep_pkg SHALL hold the state enum type (IDLE, LOAD, EXEC, STOP; 2 bits) and fault_cnt width constant.
REQ-035 One sub-module memseq_lane (FSM + counter + memory + injection), instantiated NCH times by generate; vote/compare/fault logic in the top.

Verification (AW=4, DW=8, SEED=8'hA5)
REQ-036 Reset, start pulse, no inj -> 16 LOAD, 16 EXEC with rd_data 0xAA,0xAB..down..0xA5 (cnt 15..0 ^ 0xA5), done 33 cycles after start; fault=0.
REQ-037 NCH=2, inj_en with inj_lane=2'b10 at LOAD cnt=3 -> at EXEC cnt=3 mismatch; next cycle fault=1, fault_lane=2'b11, fault_cnt=1; rd_data=0xA6.
REQ-038 NCH=3, inj_lane=3'b100 at cnt=5 -> rd_data at cnt=5 stays 0xA0; fault=1, fault_lane=3'b100, fault_cnt=1.
REQ-039 rstn=0 for one cycle at EXEC cnt=8 -> next cycle IDLE, busy=0, rd_data=0, fault cleared; new start re-runs cleanly.
REQ-040 start pulsed in LOAD and STOP -> ignored; start held high continuously -> new LOAD begins cycle after return to IDLE.
REQ-041 Sticky fault set, then clr_fault asserted in same cycle as new mismatch -> fault stays 1, fault_cnt=1.
